exe_ctrl_update_queue: RTL and testbench
========================================

Name: exe_ctrl_update_queue

Overview:
- Sits directly downstream of the control execution lane. Captures each resolved control-transfer instruction (CTI) from the lane's exeCtrl* outputs into a small FIFO.
- Drains the FIFO to the fetch-side branch predictor and BTB update port over a valid/ready handshake.
- Decouples single-cycle CTI resolution from the predictor's multi-cycle or arbitrated update port.
- Provides an almost-full back-pressure signal to issue and a sticky overflow flag.

Parameters:
DEPTH, 8, number of queue entries (>=2, need not be a power of two)
PC_W, 32, width of PC/NPC (matches SIZE_PC)
TYPE_W, 2, branch type width (matches BRANCH_TYPE_LOG)
CTI_W, 4, CTI identifier width (matches SIZE_CTI_LOG)
AFULL_MARGIN, 2, free-entry threshold for almost-full

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
laneActive_i  in  1  control lane enabled; when 0, exeCtrlValid_i is ignored
exeCtrlPC_i  in  PC_W  PC of resolved CTI
exeCtrlType_i  in  TYPE_W  branch type
exeCtrlValid_i  in  1  resolved CTI present this cycle
exeCtrlNPC_i  in  PC_W  actual next PC
exeCtrlDir_i  in  1  actual direction (1 = taken)
exeCtiID_i  in  CTI_W  CTI queue identifier
exceptionFlag_i  in  1  pipeline exception flush
updReady_i  in  1  predictor accepts head entry this cycle
updValid_o  out  1  head entry valid
updPC_o  out  PC_W  head PC
updType_o  out  TYPE_W  head type
updNPC_o  out  PC_W  head NPC
updDir_o  out  1  head direction
updCtiID_o  out  CTI_W  head CTI id
almostFull_o  out  1  count >= DEPTH-AFULL_MARGIN
count_o  out  clog2(DEPTH+1)  occupancy
overflow_o  out  1  sticky: a push was dropped because the queue was full

Behaviour:
- Reset (synchronous, active-high) sets head/tail pointers, count, overflow_o and all upd*_o outputs to 0. Reset dominates every other input in the same cycle.
- push = exeCtrlValid_i & laneActive_i & ~exceptionFlag_i.
- pop = updValid_o & updReady_i.
- Write path: on push with room (count<DEPTH, or count==DEPTH with pop in the same cycle), write {PC,Type,NPC,Dir,CtiID} at tail. Tail increments and wraps from DEPTH-1 to 0.
- Latency: an entry pushed in cycle N to an empty queue appears on upd*_o with updValid_o=1 in cycle N+1. There is no same-cycle bypass.
- Output path: upd*_o are registered and reflect the head entry. When the queue is empty, updValid_o=0 and all data outputs are 0.
- Pop advances head and wraps. If the queue is non-empty after the pop, the next entry is presented in the following cycle, giving sustained throughput of 1 per cycle.
- Simultaneous push and pop: count is unchanged. When count==1, the pushed entry becomes head in the next cycle.
- Full with push and no pop: the incoming entry is dropped and overflow_o is set to 1. overflow_o holds until reset. Existing contents are unchanged.
- Empty with updReady_i=1: no effect.
- exceptionFlag_i=1: all entries are discarded, with head=tail=0 and count=0 in the next cycle. Any same-cycle push is suppressed. A pop in that cycle is irrelevant. updValid_o=0 in the next cycle. overflow_o is not cleared.
- Branch misprediction recovery does NOT flush the queue, because queued CTIs are already resolved and still valid for training. There is no recover input.
- almostFull_o and count_o are registered-state derived, i.e. combinational from count with no input-to-output path.
- Pointer and count arithmetic uses explicit compare-and-wrap, not power-of-two truncation.

Decomposition:
- Shared package: typedef ctiUpdPkt {pc, ctrlType, npc, dir, ctiID}, and localparam COUNT_W = clog2(DEPTH+1).
- One natural sub-module: ctrl_upd_fifo_ram, a DEPTH x packet-width storage array with one write port and one read port. Pointer and handshake control stays in the top module.

Test Plan:
- Reset, then push PC=0x1000, NPC=0x2000, Dir=1, Type=2, ID=3 with updReady_i=0 -> cycle+1 updValid_o=1 with the same fields; count_o=1; values hold across 5 stalled cycles.
- Push 8 entries back-to-back with updReady_i=0 -> count_o=8, almostFull_o=1 from count 6. A 9th push -> overflow_o=1 and count stays 8. Then drain with updReady_i=1 -> 8 entries in push order (PCs 0x100..0x11C), one per cycle.
- Steady stream: push every cycle with updReady_i=1 -> count_o stays at 1, and the output sequence equals the input sequence delayed by 1 cycle, across ≥3 pointer wraps.
- With 4 entries queued, exceptionFlag_i=1 together with a push -> next cycle count_o=0, updValid_o=0, outputs 0, and the pushed entry is absent.
- laneActive_i=0 with exeCtrlValid_i=1 -> no push and count_o unchanged. Reset asserted mid-drain with 3 entries -> next cycle all outputs 0 and overflow_o=0.

Source files
------------

// File: rtl/exe_ctrl_update_queue_pkg.sv
// exe_ctrl_update_queue_pkg: shared packet type and sizing for the CTI update queue
package exe_ctrl_update_queue_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int PC_W = 32;
  localparam int TYPE_W = 2;
  localparam int CTI_W = 4;
  localparam int DEF_AFULL_MARGIN = 2;
  localparam int COUNT_W = $clog2(DEF_DEPTH + 1);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [TYPE_W-1:0] ctrlType;
    logic [PC_W-1:0] npc;
    logic dir;
    logic [CTI_W-1:0] ctiID;
  } ctiUpdPkt;
endpackage

// File: rtl/exe_ctrl_update_queue_if.sv
// exe_ctrl_update_queue_if: control-lane capture and predictor update signals
interface exe_ctrl_update_queue_if
  import exe_ctrl_update_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
);
  logic laneActive_i;
  logic [PC_W-1:0] exeCtrlPC_i;
  logic [TYPE_W-1:0] exeCtrlType_i;
  logic exeCtrlValid_i;
  logic [PC_W-1:0] exeCtrlNPC_i;
  logic exeCtrlDir_i;
  logic [CTI_W-1:0] exeCtiID_i;
  logic exceptionFlag_i;
  logic updReady_i;
  logic updValid_o;
  logic [PC_W-1:0] updPC_o;
  logic [TYPE_W-1:0] updType_o;
  logic [PC_W-1:0] updNPC_o;
  logic updDir_o;
  logic [CTI_W-1:0] updCtiID_o;
  logic almostFull_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic overflow_o;
  modport master (
    output laneActive_i, exeCtrlPC_i, exeCtrlType_i, exeCtrlValid_i, exeCtrlNPC_i,
           exeCtrlDir_i, exeCtiID_i, exceptionFlag_i, updReady_i,
    input  updValid_o, updPC_o, updType_o, updNPC_o, updDir_o, updCtiID_o,
           almostFull_o, count_o, overflow_o
  );
  modport slave (
    input  laneActive_i, exeCtrlPC_i, exeCtrlType_i, exeCtrlValid_i, exeCtrlNPC_i,
           exeCtrlDir_i, exeCtiID_i, exceptionFlag_i, updReady_i,
    output updValid_o, updPC_o, updType_o, updNPC_o, updDir_o, updCtiID_o,
           almostFull_o, count_o, overflow_o
  );
endinterface

// File: rtl/ctrl_upd_fifo_ram.sv
// ctrl_upd_fifo_ram: DEPTH-entry packet storage, one sync write port and one async read port
module ctrl_upd_fifo_ram
  import exe_ctrl_update_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic wrEn,
  input  logic [PTR_W-1:0] wrAddr,
  input  ctiUpdPkt wrData,
  input  logic [PTR_W-1:0] rdAddr,
  output ctiUpdPkt rdData
);
  ctiUpdPkt mem [DEPTH];
  // store the incoming packet at the tail slot
  always_ff @(posedge clk)
    if (wrEn) mem[wrAddr] <= wrData;
  assign rdData = mem[rdAddr];
endmodule

// File: rtl/exe_ctrl_update_queue.sv
// exe_ctrl_update_queue: buffers resolved CTIs and drains them to the predictor update port
module exe_ctrl_update_queue
  import exe_ctrl_update_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
  input logic clk,
  input logic reset,
  exe_ctrl_update_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - AFULL_MARGIN);
  logic [PTR_W-1:0] head, tail, nextHead, nextTail;
  logic [CNT_W-1:0] count, nextCount;
  logic push, pop, wrEn, updValid;
  ctiUpdPkt inPkt, rdPkt, nextPkt, updPkt;
  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return p == LAST_PTR ? '0 : p + 1'b1;
  endfunction
  assign inPkt = '{pc: bus.exeCtrlPC_i, ctrlType: bus.exeCtrlType_i, npc: bus.exeCtrlNPC_i,
                   dir: bus.exeCtrlDir_i, ctiID: bus.exeCtiID_i};
  assign push = bus.exeCtrlValid_i & bus.laneActive_i & ~bus.exceptionFlag_i;
  assign pop = updValid & bus.updReady_i;
  assign wrEn = push & (count != FULL_CNT | pop);
  ctrl_upd_fifo_ram #(.DEPTH(DEPTH)) ram (
    .clk(clk),
    .wrEn(wrEn),
    .wrAddr(tail),
    .wrData(inPkt),
    .rdAddr(nextHead),
    .rdData(rdPkt)
  );
  // next pointers/occupancy; a push that lands at the next head bypasses the array into the output register
  always_comb begin
    nextHead = pop ? incPtr(head) : head;
    nextTail = wrEn ? incPtr(tail) : tail;
    nextCount = count + CNT_W'(wrEn) - CNT_W'(pop);
    nextPkt = (wrEn && nextHead == tail) ? inPkt : rdPkt;
  end
  // queue state and registered head presentation; exception flushes but keeps the sticky overflow
  always_ff @(posedge clk)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      bus.overflow_o <= 1'b0;
      updValid <= 1'b0;
      updPkt <= '0;
    end else if (bus.exceptionFlag_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      updValid <= 1'b0;
      updPkt <= '0;
    end else begin
      head <= nextHead;
      tail <= nextTail;
      count <= nextCount;
      bus.overflow_o <= bus.overflow_o | (push & ~wrEn);
      updValid <= nextCount != '0;
      updPkt <= nextCount != '0 ? nextPkt : '0;
    end
  assign bus.updValid_o = updValid;
  assign bus.updPC_o = updPkt.pc;
  assign bus.updType_o = updPkt.ctrlType;
  assign bus.updNPC_o = updPkt.npc;
  assign bus.updDir_o = updPkt.dir;
  assign bus.updCtiID_o = updPkt.ctiID;
  assign bus.count_o = count;
  assign bus.almostFull_o = count >= AFULL_CNT;
endmodule

// File: tb/tb_exe_ctrl_update_queue.sv
// tb_exe_ctrl_update_queue: randomized and directed checking against a queue-based reference model
module tb_exe_ctrl_update_queue;
  import exe_ctrl_update_queue_pkg::*;
  localparam int DEPTH = DEF_DEPTH;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  ctiUpdPkt model[$];
  logic modelOvf = 1'b0;
  exe_ctrl_update_queue_if bus();
  exe_ctrl_update_queue dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ctiUpdPkt mk(input logic [31:0] pc, input logic [31:0] npc,
                                  input logic [1:0] t, input logic d, input logic [3:0] id);
    ctiUpdPkt p;
    p.pc = pc;
    p.npc = npc;
    p.ctrlType = t;
    p.dir = d;
    p.ctiID = id;
    return p;
  endfunction
  function automatic ctiUpdPkt rndPkt();
    return mk($urandom, $urandom, 2'($urandom), 1'($urandom), 4'($urandom));
  endfunction
  task automatic drive(input logic v, input logic la, input logic exc, input logic rdy, input ctiUpdPkt p);
    bus.exeCtrlValid_i = v;
    bus.laneActive_i = la;
    bus.exceptionFlag_i = exc;
    bus.updReady_i = rdy;
    bus.exeCtrlPC_i = p.pc;
    bus.exeCtrlNPC_i = p.npc;
    bus.exeCtrlType_i = p.ctrlType;
    bus.exeCtrlDir_i = p.dir;
    bus.exeCtiID_i = p.ctiID;
  endtask
  task automatic tick();
    ctiUpdPkt p, e;
    logic push, pop;
    p = mk(bus.exeCtrlPC_i, bus.exeCtrlNPC_i, bus.exeCtrlType_i, bus.exeCtrlDir_i, bus.exeCtiID_i);
    push = bus.exeCtrlValid_i & bus.laneActive_i & ~bus.exceptionFlag_i;
    pop = model.size() > 0 && bus.updReady_i;
    if (reset) begin
      model.delete();
      modelOvf = 1'b0;
    end else if (bus.exceptionFlag_i) model.delete();
    else begin
      if (push && model.size() == DEPTH && !pop) modelOvf = 1'b1;
      if (pop) void'(model.pop_front());
      if (push && model.size() < DEPTH) model.push_back(p);
    end
    @(posedge clk);
    #1;
    e = model.size() > 0 ? model[0] : '0;
    checkVal("valid", bus.updValid_o, model.size() != 0);
    checkVal("pc", bus.updPC_o, e.pc);
    checkVal("type", bus.updType_o, e.ctrlType);
    checkVal("npc", bus.updNPC_o, e.npc);
    checkVal("dir", bus.updDir_o, e.dir);
    checkVal("ctiId", bus.updCtiID_o, e.ctiID);
    checkVal("count", bus.count_o, model.size());
    checkVal("almostFull", bus.almostFull_o, model.size() >= DEPTH - DEF_AFULL_MARGIN);
    checkVal("overflow", bus.overflow_o, modelOvf);
  endtask
  initial begin
    reset = 1'b1;
    drive(1, 1, 0, 1, rndPkt());
    repeat (2) tick();
    reset = 1'b0;
    drive(0, 1, 0, 0, '0);
    tick();
    drive(1, 1, 0, 0, mk(32'h1000, 32'h2000, 2'd2, 1'b1, 4'd3));
    tick();
    drive(0, 1, 0, 0, rndPkt());
    repeat (5) tick();
    drive(1, 1, 0, 1, '0);
    tick();
    drive(0, 1, 0, 1, '0);
    repeat (2) tick();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 1, 0, 0, mk(32'h100 + 32'(4 * i), $urandom, 2'($urandom), 1'($urandom), 4'(i)));
      tick();
    end
    drive(0, 1, 0, 1, '0);
    repeat (DEPTH + 2) tick();
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      drive(1, 1, 0, 1, rndPkt());
      tick();
    end
    drive(0, 1, 0, 1, '0);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, rndPkt());
      tick();
    end
    drive(1, 1, 1, 0, rndPkt());
    tick();
    drive(0, 1, 0, 0, '0);
    tick();
    drive(1, 1, 0, 0, rndPkt());
    tick();
    drive(1, 0, 0, 0, rndPkt());
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, rndPkt());
      tick();
    end
    drive(0, 1, 0, 1, '0);
    tick();
    reset = 1'b1;
    drive(1, 1, 0, 1, rndPkt());
    tick();
    reset = 1'b0;
    drive(0, 1, 0, 0, '0);
    tick();
    for (int ph = 0; ph < 3; ph++)
      for (int i = 0; i < 600; i++) begin
        reset = $urandom_range(0, 299) == 0;
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 3) < ph + 1, rndPkt());
        tick();
      end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
